uart_boot_ctrl: RTL and testbench

Sequences the UART receive datapath at power-up and after each reset. In LOAD mode it parses a length-prefixed program image from received bytes, assembles 32-bit little-endian words and writes them to instruction memory. It then sends one ACK byte through the UART transmitter, releases the core (`boot_done`), and switches to RUN mode. In RUN mode every received byte is buffered in a FIFO, which the core's input instruction reads.

---
 rtl/uart_boot_pkg.sv | 16 +
 rtl/byte_fifo.sv | 44 ++++
 rtl/uart_boot_ctrl.sv | 159 +++++++++++++++
 tb/tb_uart_boot_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_boot_pkg.sv
// Shared types and constants for the UART boot controller.
package uart_boot_pkg;

  typedef enum logic [2:0] {
    WAIT_LEN,
    RECV_WORD,
    SEND_ACK,
    RUN,
    ERROR
  } boot_state_t;

  localparam logic [7:0] DEFAULT_ACK_BYTE = 8'hAA;
  localparam int LEN_BYTES  = 4;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous show-ahead byte FIFO; a push into a full FIFO succeeds only alongside a pop.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [7:0]  mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  // The extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_boot_ctrl.sv
// Boot sequencer: loads a length-prefixed image into instruction memory over UART,
// acknowledges it, then buffers RUN-mode bytes for the core.
module uart_boot_ctrl
  import uart_boot_pkg::*;
#(
  parameter int         IMEM_ADDR_W = 14,
  parameter int         FIFO_DEPTH  = 16,
  parameter logic [7:0] ACK_BYTE    = DEFAULT_ACK_BYTE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  input  logic                   rx_ferr,
  output logic                   imem_we,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  output logic [31:0]            imem_wdata,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  input  logic                   tx_busy,
  output logic                   boot_done,
  output logic                   boot_err,
  input  logic                   cpu_rd_en,
  output logic [7:0]             cpu_rd_data,
  output logic                   cpu_rd_empty,
  output logic                   fifo_ovf
);

  localparam logic [31:0] MAX_WORDS = 32'd1 << IMEM_ADDR_W;

  boot_state_t            state, state_next;
  logic [1:0]             byte_idx, byte_idx_next;
  logic [31:0]            sr, sr_next;
  logic [IMEM_ADDR_W-1:0] addr, addr_next;
  logic [IMEM_ADDR_W:0]   remaining, remaining_next;
  logic                   imem_we_next;
  logic [IMEM_ADDR_W-1:0] imem_addr_next;
  logic [31:0]            imem_wdata_next;
  logic                   tx_start_next;
  logic [31:0]            assembled;
  logic                   len_last, word_last;
  logic                   fifo_push, fifo_full, ovf_set;
  logic                   unused_sr_low;

  // First byte received ends up as the LSB once four bytes have shifted in.
  assign assembled     = {rx_data, sr[31:8]};
  assign len_last      = (byte_idx == 2'(LEN_BYTES - 1));
  assign word_last     = (byte_idx == 2'(WORD_BYTES - 1));
  assign unused_sr_low = ^sr[7:0];

  assign boot_done = (state == RUN);
  assign boot_err  = (state == ERROR);
  assign tx_data   = ACK_BYTE;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= WAIT_LEN;
      byte_idx   <= '0;
      sr         <= '0;
      addr       <= '0;
      remaining  <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      tx_start   <= 1'b0;
      fifo_ovf   <= 1'b0;
    end else begin
      state      <= state_next;
      byte_idx   <= byte_idx_next;
      sr         <= sr_next;
      addr       <= addr_next;
      remaining  <= remaining_next;
      imem_we    <= imem_we_next;
      imem_addr  <= imem_addr_next;
      imem_wdata <= imem_wdata_next;
      tx_start   <= tx_start_next;
      fifo_ovf   <= fifo_ovf | ovf_set;
    end
  end

  always_comb begin
    state_next      = state;
    byte_idx_next   = byte_idx;
    sr_next         = sr;
    addr_next       = addr;
    remaining_next  = remaining;
    imem_we_next    = 1'b0;
    imem_addr_next  = imem_addr;
    imem_wdata_next = imem_wdata;
    tx_start_next   = 1'b0;

    case (state)
      WAIT_LEN: begin
        if (rx_valid) begin
          if (rx_ferr) begin
            state_next = ERROR;
          end else begin
            sr_next       = assembled;
            byte_idx_next = byte_idx + 2'd1;
            if (len_last) begin
              if (assembled == 32'd0) begin
                state_next = SEND_ACK;
              end else if (assembled > MAX_WORDS) begin
                state_next = ERROR;
              end else begin
                state_next     = RECV_WORD;
                addr_next      = '0;
                remaining_next = assembled[IMEM_ADDR_W:0];
              end
            end
          end
        end
      end
      RECV_WORD: begin
        if (rx_valid) begin
          if (rx_ferr) begin
            state_next = ERROR;
          end else begin
            sr_next       = assembled;
            byte_idx_next = byte_idx + 2'd1;
            if (word_last) begin
              imem_we_next    = 1'b1;
              imem_addr_next  = addr;
              imem_wdata_next = assembled;
              addr_next       = addr + 1'b1;
              remaining_next  = remaining - 1'b1;
              if (remaining == (IMEM_ADDR_W+1)'(1)) state_next = SEND_ACK;
            end
          end
        end
      end
      SEND_ACK: begin
        if (!tx_busy) begin
          tx_start_next = 1'b1;
          state_next    = RUN;
        end
      end
      default: ;
    endcase
  end

  // Framing-error bytes never reach the FIFO and never count as overflow.
  assign fifo_push = (state == RUN) && rx_valid && !rx_ferr;
  assign ovf_set   = fifo_push && fifo_full && !cpu_rd_en;

  byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_data(rx_data),
    .pop      (cpu_rd_en),
    .head     (cpu_rd_data),
    .full     (fifo_full),
    .empty    (cpu_rd_empty)
  );

endmodule

// File: tb/tb_uart_boot_ctrl.sv
// Self-checking bench for uart_boot_ctrl: a byte-level boot/FIFO model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_uart_boot_ctrl;

  localparam int ADDR_W    = 4;
  localparam int DEPTH     = 4;
  localparam int MAX_WORDS = 16;
  localparam int P_LEN = 0, P_WORD = 1, P_ACK = 2, P_RUN = 3, P_ERR = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              rx_ferr = 1'b0;
  logic              tx_busy = 1'b0;
  logic              cpu_rd_en = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              boot_done;
  logic              boot_err;
  logic [7:0]        cpu_rd_data;
  logic              cpu_rd_empty;
  logic              fifo_ovf;

  always #5 clk = ~clk;

  uart_boot_ctrl #(
    .IMEM_ADDR_W(ADDR_W),
    .FIFO_DEPTH (DEPTH),
    .ACK_BYTE   (8'hAA)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ferr     (rx_ferr),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .boot_done   (boot_done),
    .boot_err    (boot_err),
    .cpu_rd_en   (cpu_rd_en),
    .cpu_rd_data (cpu_rd_data),
    .cpu_rd_empty(cpu_rd_empty),
    .fifo_ovf    (fifo_ovf)
  );

  int checks = 0;
  int failures = 0;

  // Model state
  int                phase;
  logic [7:0]        collect[$];
  int                m_addr, m_left;
  logic              exp_we;
  logic [ADDR_W-1:0] exp_addr;
  logic [31:0]       exp_data;
  logic [7:0]        fifo_q[$];
  logic              m_ovf;

  // Compare-process bookkeeping
  bit                checking = 0;
  bit                prev_valid, prev_ack, prev_busy;
  logic              exp_tx;
  bit                have_last;
  logic [ADDR_W-1:0] last_addr;
  logic [31:0]       last_data;
  int                tx_count;
  logic [ADDR_W-1:0] wr_addr_log[$];
  logic [31:0]       wr_data_log[$];

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic void model_reset();
    phase = P_LEN;
    collect.delete();
    m_addr = 0;
    m_left = 0;
    exp_we = 1'b0;
    fifo_q.delete();
    m_ovf = 1'b0;
    have_last = 0;
    prev_valid = 0;
  endfunction

  function automatic void model_update(input logic [7:0] d, input logic f, input logic push, input logic pop);
    longint w;
    if (push && (phase == P_LEN || phase == P_WORD)) begin
      if (f) begin
        phase = P_ERR;
        collect.delete();
      end else begin
        collect.push_back(d);
        if (collect.size() == 4) begin
          w = longint'(collect[0]) + 256 * longint'(collect[1])
            + 65536 * longint'(collect[2]) + 16777216 * longint'(collect[3]);
          collect.delete();
          if (phase == P_LEN) begin
            if (w == 0) phase = P_ACK;
            else if (w > MAX_WORDS) phase = P_ERR;
            else begin
              phase  = P_WORD;
              m_addr = 0;
              m_left = int'(w);
            end
          end else begin
            exp_we   = 1'b1;
            exp_addr = ADDR_W'(m_addr % MAX_WORDS);
            exp_data = 32'(w);
            m_addr++;
            m_left--;
            if (m_left == 0) phase = P_ACK;
          end
        end
      end
    end
    if (pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (push && phase == P_RUN && !f) begin
      if (fifo_q.size() < DEPTH) fifo_q.push_back(d);
      else m_ovf = 1'b1;
    end
  endfunction

  task automatic apply_stimulus(input logic [7:0] d, input logic f, input logic push, input logic pop);
    @(posedge clk); #1;
    rx_valid  = push;
    rx_data   = d;
    rx_ferr   = f;
    cpu_rd_en = pop;
    @(posedge clk); #1;
    rx_valid  = 1'b0;
    rx_ferr   = 1'b0;
    cpu_rd_en = 1'b0;
    model_update(d, f, push, pop);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic f = 1'b0);
    apply_stimulus(d, f, 1'b1, 1'b0);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    checking = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset = 1'b1;
    tx_count = 0;
    wr_addr_log.delete();
    wr_data_log.delete();
    checking = 1;
  endtask

  // Per-cycle comparison against the model; outputs sampled mid-cycle.
  always @(negedge clk) begin
    if (checking) begin
      exp_tx = prev_valid && prev_ack && !prev_busy;
      check_output("tx_start", tx_start, exp_tx);
      if (tx_start) begin
        check_output("tx_data", tx_data, 8'hAA);
        tx_count++;
      end
      if (exp_tx) phase = P_RUN;
      prev_valid = 1;
      prev_ack   = (phase == P_ACK);
      prev_busy  = tx_busy;

      check_output("boot_done", boot_done, phase == P_RUN);
      check_output("boot_err", boot_err, phase == P_ERR);

      check_output("imem_we", imem_we, exp_we);
      if (imem_we) begin
        wr_addr_log.push_back(imem_addr);
        wr_data_log.push_back(imem_wdata);
      end
      if (exp_we) begin
        check_output("imem_addr", imem_addr, exp_addr);
        check_output("imem_wdata", imem_wdata, exp_data);
        last_addr = exp_addr;
        last_data = exp_data;
        have_last = 1;
        exp_we    = 1'b0;
      end else if (have_last) begin
        check_output("imem_addr hold", imem_addr, last_addr);
        check_output("imem_wdata hold", imem_wdata, last_data);
      end

      check_output("cpu_rd_empty", cpu_rd_empty, fifo_q.size() == 0);
      if (fifo_q.size() != 0) check_output("cpu_rd_data", cpu_rd_data, fifo_q[0]);
      check_output("fifo_ovf", fifo_ovf, m_ovf);
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    model_reset();

    // Reset state and a normal two-word load
    do_reset();
    check_output("reset boot_done", boot_done, 1'b0);
    check_output("reset boot_err", boot_err, 1'b0);
    check_output("reset imem_we", imem_we, 1'b0);
    check_output("reset tx_start", tx_start, 1'b0);
    check_output("reset empty", cpu_rd_empty, 1'b1);
    check_output("reset fifo_ovf", fifo_ovf, 1'b0);
    send_word(32'h0000_0002);
    send_word(32'h1234_5678);
    send_word(32'hDEAD_BEEF);
    idle(3);
    check_output("load write count", wr_addr_log.size(), 2);
    check_output("load addr0", wr_addr_log[0], 0);
    check_output("load data0", wr_data_log[0], 32'h1234_5678);
    check_output("load addr1", wr_addr_log[1], 1);
    check_output("load data1", wr_data_log[1], 32'hDEAD_BEEF);
    check_output("load tx count", tx_count, 1);
    check_output("load boot_done", boot_done, 1'b1);

    // Empty image with the transmitter busy, then RUN-mode FIFO overflow
    do_reset();
    tx_busy = 1'b1;
    send_word(32'h0);
    idle(10);
    check_output("busy tx count", tx_count, 0);
    check_output("busy boot_done", boot_done, 1'b0);
    tx_busy = 1'b0;
    idle(3);
    check_output("empty tx count", tx_count, 1);
    check_output("empty boot_done", boot_done, 1'b1);
    check_output("empty write count", wr_addr_log.size(), 0);
    for (int i = 0; i < 5; i++) send_byte(8'h41 + 8'(i));
    check_output("ovf set", fifo_ovf, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check_output("pop head", cpu_rd_data, 8'h41 + 8'(i));
      apply_stimulus(8'h00, 1'b0, 1'b0, 1'b1);
    end
    check_output("drained empty", cpu_rd_empty, 1'b1);
    apply_stimulus(8'h00, 1'b0, 1'b0, 1'b1);
    check_output("pop on empty", cpu_rd_empty, 1'b1);

    // Simultaneous push/pop while full; framing-error byte dropped silently
    do_reset();
    send_word(32'h0);
    idle(2);
    send_byte(8'h99, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(8'h51 + 8'(i));
    apply_stimulus(8'h55, 1'b0, 1'b1, 1'b1);
    check_output("push+pop ovf", fifo_ovf, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check_output("push+pop head", cpu_rd_data, 8'h52 + 8'(i));
      apply_stimulus(8'h00, 1'b0, 1'b0, 1'b1);
    end
    check_output("push+pop empty", cpu_rd_empty, 1'b1);

    // Framing error on the 6th byte of an N=1 image
    do_reset();
    send_word(32'h1);
    send_byte(8'h11);
    send_byte(8'h22, 1'b1);
    check_output("ferr boot_err", boot_err, 1'b1);
    for (int i = 0; i < 5; i++) send_byte(8'h33 + 8'(i));
    idle(2);
    check_output("ferr write count", wr_addr_log.size(), 0);
    check_output("ferr boot_done", boot_done, 1'b0);
    do_reset();
    check_output("ferr cleared err", boot_err, 1'b0);
    check_output("ferr cleared done", boot_done, 1'b0);

    // Oversize image rejected; maximum image accepted
    send_word(32'd17);
    idle(1);
    check_output("oversize err", boot_err, 1'b1);
    do_reset();
    send_word(32'd16);
    for (int i = 0; i < 16; i++)
      send_word({8'(i + 8'h30), 8'(i + 8'h20), 8'(i + 8'h10), 8'(i)});
    idle(3);
    check_output("max write count", wr_addr_log.size(), 16);
    check_output("max last addr", wr_addr_log[15], 15);
    check_output("max last data", wr_data_log[15], 32'h3F2F_1F0F);
    check_output("max tx count", tx_count, 1);
    check_output("max boot_done", boot_done, 1'b1);

    // Reset in the middle of a load, then a fresh load
    do_reset();
    send_word(32'h2);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    do_reset();
    send_word(32'h1);
    send_word(32'hCAFE_F00D);
    idle(3);
    check_output("reload write count", wr_addr_log.size(), 1);
    check_output("reload addr", wr_addr_log[0], 0);
    check_output("reload data", wr_data_log[0], 32'hCAFE_F00D);
    check_output("reload boot_done", boot_done, 1'b1);

    checking = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
